multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control state machine of the multicycle MIPS datapath.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Each cycle it drives the ALU operand selects (source A and source B muxes), ALU operation, PC/IR/register-file/memory enables and write-back muxes.
- Memory accesses use a ready handshake with a timeout; sits between the instruction register and all datapath muxes.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready before the FSM enters the fault state (range 2..31).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- alu_src_a  out  2  00=PC, 01=A; 10 and 11 are not driven.
- alu_src_b  out  3  000=B, 001=const 4, 010=sign-ext imm, 011=sign-ext imm<<2, 100=A.
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg  out  1 each  standard multicycle controls.
- fault  out  1  sticky: illegal opcode/funct or memory timeout.
- state_out  out  4  current state encoding, for debug.

Behaviour:
- Moore outputs decoded from state. Only exceptions: in FETCH, pc_write and ir_write equal mem_ready. Unlisted outputs are 0.
- Reset:
  - While reset=1, the next state is RST. All outputs are 0, alu_src_b=000, fault=0, and the wait counter is cleared.
  - RST goes to FETCH on the next clock.
  - Reset mid-access abandons the access with no write strobes.
- FETCH: mem_read=1, iord=0, src_a=00, src_b=001, alu_op add, pc_source 00. Holds until mem_ready=1, then goes to DECODE.
- DECODE: src_a=00, src_b=011, alu_op add (branch target into ALUOut). Dispatch on opcode:
  - 0x00 goes to EXEC_R.
  - 0x08 goes to EXEC_I.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x04 goes to BRANCH.
  - 0x02 goes to JUMP.
  - Any other opcode goes to FAULT.
- EXEC_R: src_a=01, src_b=000, alu_op from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct goes to FAULT; otherwise next state is WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- EXEC_I: src_a=01, src_b=010, add, then WB_I.
- WB_I: reg_write=1, reg_dst=0, then FETCH.
- MEM_ADDR: src_a=01, src_b=010, add. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1, held until mem_ready, then WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEM_WR: iord=1, mem_write=1, held until mem_ready, then FETCH.
- BRANCH: src_a=01, src_b=000, sub, pc_write_cond=1, pc_source=01, then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- src_b=100 is never issued by this FSM; it is reserved for the future comparison sequencer.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle that mem_ready=0.
  - If it reaches MEM_TIMEOUT-1 with mem_ready still 0, the next state is FAULT.
  - mem_ready=1 in the same cycle as the limit wins: the access completes normally.
- FAULT: all strobes 0, fault=1. Absorbing; only reset exits.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Latency with mem_ready tied high:
  - R/addi: 4 cycles.
  - lw: 5 cycles.
  - sw, beq, j: 4, 3 and 3 cycles respectively.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - Opcode and funct constants.
  - alu_src_a/alu_src_b/alu_op/pc_source encodings.
  - 4-bit state encoding: RST=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, WB_MEM=9, MEM_WR=10, BRANCH=11, JUMP=12, FAULT=15.
- One combinational sub-module, alu_funct_decoder: funct in, alu_op plus a valid flag out.

Test Plan:
- add (op 0x00, funct 0x20), mem_ready=1: state_out 1,2,3,4,1. At state 3, src_a=01, src_b=000, alu_op=000. At state 4, reg_write=1, reg_dst=1.
- lw (0x23), mem_ready low for 3 cycles in MEM_RD: MEM_RD lasts 4 cycles with mem_read=1 and iord=1. Then WB_MEM with mem_to_reg=1, reg_write=1.
- beq (0x04), zero=1: in DECODE, src_b=011. In BRANCH, src_b=000, alu_op=001, pc_write_cond=1, pc_source=01. Returns to FETCH after 3 cycles total.
- Opcode 0x3F, or op 0x00 with funct 0x18: FAULT reached, fault=1 sticky for 10 idle cycles. Reset gives state_out=0 and fault=0, then FETCH next cycle.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: FAULT after exactly 4 FETCH cycles. Repeat with mem_ready=1 on the 4th cycle: DECODE instead.
- Reset asserted during MEM_WR: mem_write=0 in the cycle after the reset edge, state_out=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: instruction field
// constants, datapath mux/ALU encodings, FSM state encoding, the per-state
// control word and the state-to-control decode used by the main FSM.
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned WAIT_W   = 5;  // holds MEM_TIMEOUT-1 for timeouts up to 31

  // Opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    SRC_A_PC  = 2'b00,
    SRC_A_REG = 2'b01
  } src_a_e;

  // SRC_B_A is reserved for the comparison sequencer; this FSM never issues it.
  typedef enum logic [2:0] {
    SRC_B_REG     = 3'b000,
    SRC_B_FOUR    = 3'b001,
    SRC_B_IMM     = 3'b010,
    SRC_B_IMM_SH2 = 3'b011,
    SRC_B_A       = 3'b100
  } src_b_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [STATE_W-1:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_FAULT    = 4'd15
  } state_e;

  // Registered control word; ir_write is not here because it only ever
  // follows mem_ready in FETCH.
  typedef struct packed {
    src_a_e  alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    logic    pc_write;
    logic    pc_write_cond;
    pc_src_e pc_source;
    logic    mem_read;
    logic    mem_write;
    logic    iord;
    logic    reg_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    fault;
  } ctrl_t;

  // Moore decode of a state into its control word; r_op feeds EXEC_R only.
  function automatic ctrl_t state_ctrl(input state_e s, input alu_op_e r_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = SRC_B_FOUR;
        c.mem_read  = 1'b1;
      end
      S_DECODE: c.alu_src_b = SRC_B_IMM_SH2;
      S_EXEC_R: begin
        c.alu_src_a = SRC_A_REG;
        c.alu_src_b = SRC_B_REG;
        c.alu_op    = r_op;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = SRC_A_REG;
        c.alu_src_b = SRC_B_IMM;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_MEM_RD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRC_A_REG;
        c.alu_src_b     = SRC_B_REG;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_JUMP;
      end
      S_FAULT: c.fault = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_funct_decoder.sv
// R-type funct field to ALU operation decoder.
//   funct_i  : IR[5:0]
//   alu_op_o : ALU operation (add when the funct is not recognised)
//   valid_o  : 1 when funct_i is one of add/sub/and/or/slt
module alu_funct_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct_i,
  output alu_op_e            alu_op_o,
  output logic               valid_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath muxes,
// ALU operation and enables. Memory accesses wait on mem_ready with a timeout.
//   clk, reset         : clock, synchronous active-high reset
//   opcode, funct      : IR[31:26], IR[5:0]
//   zero               : ALU zero flag (consumed by the PC gate downstream)
//   mem_ready          : memory completed the current access this cycle
//   alu_src_a/_b, alu_op, pc_source, pc_write(_cond), ir_write, mem_read,
//   mem_write, iord, reg_write, reg_dst, mem_to_reg : datapath controls
//   fault              : sticky illegal-instruction / memory-timeout flag
//   state_out          : current state encoding
module multicycle_control_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [1:0]          alu_src_a,
  output logic [2:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                fault,
  output logic [STATE_W-1:0]  state_out
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  ctrl_t             ctrl_q, ctrl_d;

  alu_op_e r_alu_op;
  logic    funct_valid;
  logic    in_wait_state;
  logic    timeout;
  logic    fetch_strobe_c;
  logic    unused_zero;

  // The branch decision happens in the PC-write gate, not here.
  assign unused_zero = zero;

  alu_funct_decoder u_funct_dec (
    .funct_i  (funct),
    .alu_op_o (r_alu_op),
    .valid_o  (funct_valid)
  );

  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                         (state_q == S_MEM_WR);
  // mem_ready on the limit cycle still completes the access.
  assign timeout = in_wait_state && !mem_ready && (wait_cnt_q == WAIT_LIMIT);

  // Next-state, wait counter and next control word.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FAULT;
        endcase
      end
      S_EXEC_R:   state_d = funct_valid ? S_WB_R : S_FAULT;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FAULT;
      end
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_WB_MEM;
        else if (timeout) state_d = S_FAULT;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase

    // Any state change clears the counter, which covers entry into every
    // waiting state; staying put while memory is busy counts up.
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (in_wait_state && !mem_ready)
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    // Outputs are registered from the next state so they line up with state_q.
    ctrl_d = state_ctrl(state_d, r_alu_op);
  end

  // State, counter and control-word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  // PC and IR load in FETCH on the very cycle memory returns the instruction.
  assign fetch_strobe_c = (state_q == S_FETCH) && mem_ready && !reset;

  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_write      = ctrl_q.pc_write | fetch_strobe_c;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign pc_source     = ctrl_q.pc_source;
  assign ir_write      = fetch_strobe_c;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign iord          = ctrl_q.iord;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign fault         = ctrl_q.fault;
  assign state_out     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (MEM_TIMEOUT=4): a per-cycle
// vector table with expected state plus an output model, followed by
// hand-written sequences for sticky fault, branch controls and reset mid-write.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [2:0] alu_op;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       fault;
  logic [3:0] state_out;

  int checks;
  int failures;

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .fault         (fault),
    .state_out     (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {src_a, src_b, alu_op, pc_write, pc_write_cond, pc_source, ir_write,
  //  mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, fault}
  logic [19:0] act_bus;
  assign act_bus = {alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond,
                    pc_source, ir_write, mem_read, mem_write, iord,
                    reg_write, reg_dst, mem_to_reg, fault};

  // Expected outputs for a given state, written from the state table.
  function automatic logic [19:0] exp_out(input logic [3:0] st, input logic rdy,
                                          input logic rst, input logic [5:0] fn);
    logic [1:0] sa, ps;
    logic [2:0] sb, op;
    logic pw, pwc, irw, mr, mw, io, rw, rd, m2r, flt;
    sa = 2'b00; sb = 3'b000; op = 3'b000; ps = 2'b00;
    pw = 0; pwc = 0; irw = 0; mr = 0; mw = 0; io = 0; rw = 0; rd = 0; m2r = 0; flt = 0;
    case (st)
      4'd1:  begin sb = 3'b001; mr = 1; pw = rdy & ~rst; irw = rdy & ~rst; end
      4'd2:  sb = 3'b011;
      4'd3:  begin
        sa = 2'b01; sb = 3'b000;
        case (fn)
          6'h22:   op = 3'b001;
          6'h24:   op = 3'b010;
          6'h25:   op = 3'b011;
          6'h2A:   op = 3'b100;
          default: op = 3'b000;
        endcase
      end
      4'd4:  begin rw = 1; rd = 1; end
      4'd5:  begin sa = 2'b01; sb = 3'b010; end
      4'd6:  rw = 1;
      4'd7:  begin sa = 2'b01; sb = 3'b010; end
      4'd8:  begin io = 1; mr = 1; end
      4'd9:  begin rw = 1; m2r = 1; end
      4'd10: begin io = 1; mw = 1; end
      4'd11: begin sa = 2'b01; sb = 3'b000; op = 3'b001; pwc = 1; ps = 2'b01; end
      4'd12: begin pw = 1; ps = 2'b10; end
      4'd15: flt = 1;
      default: ;
    endcase
    return {sa, sb, op, pw, pwc, ps, irw, mr, mw, io, rw, rd, m2r, flt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic [3:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy);
    reset = rst; opcode = op; funct = fn; mem_ready = rdy;
    zero = (op == 6'h04);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive(v.rst, v.op, v.fn, v.rdy);
    check($sformatf("vec%0d state", idx), 32'(state_out), 32'(v.st));
    check($sformatf("vec%0d outputs", idx), 32'(act_bus),
          32'(exp_out(v.st, v.rdy, v.rst, v.fn)));
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive(1'b1, 6'h00, 6'h00, 1'b0);
    tick();

    // Each row: inputs for this cycle and the state expected during it.
    add(1, 6'h00, 6'h00, 0, 4'd0);
    add(0, 6'h00, 6'h00, 0, 4'd0);
    // add, sub, slt, or, and
    add(0, 6'h00, 6'h20, 1, 4'd1); add(0, 6'h00, 6'h20, 1, 4'd2);
    add(0, 6'h00, 6'h20, 1, 4'd3); add(0, 6'h00, 6'h20, 1, 4'd4);
    add(0, 6'h00, 6'h22, 1, 4'd1); add(0, 6'h00, 6'h22, 1, 4'd2);
    add(0, 6'h00, 6'h22, 1, 4'd3); add(0, 6'h00, 6'h22, 1, 4'd4);
    add(0, 6'h00, 6'h2A, 1, 4'd1); add(0, 6'h00, 6'h2A, 1, 4'd2);
    add(0, 6'h00, 6'h2A, 1, 4'd3); add(0, 6'h00, 6'h2A, 1, 4'd4);
    add(0, 6'h00, 6'h25, 1, 4'd1); add(0, 6'h00, 6'h25, 1, 4'd2);
    add(0, 6'h00, 6'h25, 1, 4'd3); add(0, 6'h00, 6'h25, 1, 4'd4);
    add(0, 6'h00, 6'h24, 1, 4'd1); add(0, 6'h00, 6'h24, 1, 4'd2);
    add(0, 6'h00, 6'h24, 1, 4'd3); add(0, 6'h00, 6'h24, 1, 4'd4);
    // addi
    add(0, 6'h08, 6'h00, 1, 4'd1); add(0, 6'h08, 6'h00, 1, 4'd2);
    add(0, 6'h08, 6'h00, 1, 4'd5); add(0, 6'h08, 6'h00, 1, 4'd6);
    // sw
    add(0, 6'h2B, 6'h00, 1, 4'd1); add(0, 6'h2B, 6'h00, 1, 4'd2);
    add(0, 6'h2B, 6'h00, 1, 4'd7); add(0, 6'h2B, 6'h00, 1, 4'd10);
    // j
    add(0, 6'h02, 6'h00, 1, 4'd1); add(0, 6'h02, 6'h00, 1, 4'd2);
    add(0, 6'h02, 6'h00, 1, 4'd12);
    // beq
    add(0, 6'h04, 6'h00, 1, 4'd1); add(0, 6'h04, 6'h00, 1, 4'd2);
    add(0, 6'h04, 6'h00, 1, 4'd11);
    // lw, MEM_RD stalls 3 cycles and completes on the timeout-limit cycle
    add(0, 6'h23, 6'h00, 1, 4'd1); add(0, 6'h23, 6'h00, 1, 4'd2);
    add(0, 6'h23, 6'h00, 0, 4'd7); add(0, 6'h23, 6'h00, 0, 4'd8);
    add(0, 6'h23, 6'h00, 0, 4'd8); add(0, 6'h23, 6'h00, 0, 4'd8);
    add(0, 6'h23, 6'h00, 1, 4'd8); add(0, 6'h23, 6'h00, 0, 4'd9);
    // FETCH with mem_ready on the 4th cycle still decodes
    add(0, 6'h02, 6'h00, 0, 4'd1); add(0, 6'h02, 6'h00, 0, 4'd1);
    add(0, 6'h02, 6'h00, 0, 4'd1); add(0, 6'h02, 6'h00, 1, 4'd1);
    add(0, 6'h02, 6'h00, 0, 4'd2); add(0, 6'h02, 6'h00, 0, 4'd12);
    // illegal funct 0x18
    add(0, 6'h00, 6'h18, 1, 4'd1); add(0, 6'h00, 6'h18, 1, 4'd2);
    add(0, 6'h00, 6'h18, 1, 4'd3); add(0, 6'h00, 6'h18, 1, 4'd15);
    add(0, 6'h00, 6'h18, 0, 4'd15); add(1, 6'h00, 6'h18, 0, 4'd15);
    add(0, 6'h00, 6'h20, 0, 4'd0);
    // FETCH timeout: four idle FETCH cycles then FAULT
    add(0, 6'h00, 6'h20, 0, 4'd1); add(0, 6'h00, 6'h20, 0, 4'd1);
    add(0, 6'h00, 6'h20, 0, 4'd1); add(0, 6'h00, 6'h20, 0, 4'd1);
    add(0, 6'h00, 6'h20, 1, 4'd15); add(1, 6'h00, 6'h20, 1, 4'd15);
    add(0, 6'h00, 6'h20, 0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Illegal opcode 0x3F: FAULT is sticky for 10 cycles whatever mem_ready does.
    drive(0, 6'h3F, 6'h00, 1); check("op3f fetch", 32'(state_out), 32'd1); tick();
    drive(0, 6'h3F, 6'h00, 1); check("op3f decode", 32'(state_out), 32'd2); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 6'h3F, 6'h00, 1'($urandom_range(0, 1)));
      check($sformatf("sticky fault %0d", i), 32'(fault), 32'd1);
      check($sformatf("sticky state %0d", i), 32'(state_out), 32'd15);
      tick();
    end
    drive(1, 6'h3F, 6'h00, 0); tick();
    drive(0, 6'h04, 6'h00, 1);
    check("reset clears state", 32'(state_out), 32'd0);
    check("reset clears fault", 32'(fault), 32'd0);
    tick();
    check("fetch after reset", 32'(state_out), 32'd1);

    // beq control details
    tick();
    check("beq decode src_b", 32'(alu_src_b), 32'd3);
    tick();
    check("beq state", 32'(state_out), 32'd11);
    check("beq src_b", 32'(alu_src_b), 32'd0);
    check("beq alu_op", 32'(alu_op), 32'd1);
    check("beq pc_write_cond", 32'(pc_write_cond), 32'd1);
    check("beq pc_source", 32'(pc_source), 32'd1);
    tick();
    check("beq back to fetch", 32'(state_out), 32'd1);

    // sw stalled in MEM_WR, then reset abandons the write
    drive(0, 6'h2B, 6'h00, 1); tick();
    tick();
    drive(0, 6'h2B, 6'h00, 0); tick();
    check("sw in mem_wr", 32'(state_out), 32'd10);
    check("sw mem_write", 32'(mem_write), 32'd1);
    drive(1, 6'h2B, 6'h00, 0); tick();
    check("reset mid-write mem_write", 32'(mem_write), 32'd0);
    check("reset mid-write state", 32'(state_out), 32'd0);
    drive(0, 6'h2B, 6'h00, 0); tick();
    check("fetch after mid-write reset", 32'(state_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
